// File: rtl/gbuff_out_drain_if.sv
// Handshake and buffer-port bundle for the OUT buffer drain block.
// master: the side that drives start/len, models the buffer and acts as the host.
// slave : the drain block itself.
interface gbuff_out_drain_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 8
);
  logic              start;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W:0]    len;
  logic              gbuf_wr_en;
  logic [IDX_W-1:0]  gbuf_index;
  logic [WORD_W-1:0] gbuf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, base_idx, len, gbuf_rdata, out_ready,
    input  gbuf_wr_en, gbuf_index, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, base_idx, len, gbuf_rdata, out_ready,
    output gbuf_wr_en, gbuf_index, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/gbuff_out_drain.sv
// Streams len words of the OUT global buffer, starting at base_idx, to the host.
// A 2-entry skid FIFO covers the buffer's 1-cycle read latency and host stalls.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing buffer reads (a zero-length drain spends one cycle here)
// FLUSH | all reads issued, draining the FIFO until the last beat transfers
// FIN   | done pulse, busy low, back to IDLE next cycle
module gbuff_out_drain #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  gbuff_out_drain_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, FIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W:0]    len_q;
  logic [IDX_W:0]    rd_cnt_q;
  logic [IDX_W:0]    beats_q;
  logic              inflight_q;
  logic [WORD_W-1:0] fifo_mem [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic start_ok, valid, pop, push, issue, last_issue, last_beat;

  assign start_ok   = (state_q == IDLE) && bus.start;
  assign valid      = (count_q != 2'd0);
  assign pop        = valid && bus.out_ready;
  assign push       = inflight_q;
  // Occupancy after this cycle's pop plus the read in flight must leave room for one more.
  assign issue      = (state_q == READ) && (rd_cnt_q < len_q) &&
                      ((3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign last_issue = issue && ((rd_cnt_q + (IDX_W+1)'(1)) == len_q);
  assign last_beat  = valid && (beats_q == (len_q - (IDX_W+1)'(1)));

  assign bus.gbuf_wr_en = 1'b0;
  assign bus.gbuf_index = idx_q;
  assign bus.out_valid  = valid;
  assign bus.out_data   = fifo_mem[rd_ptr_q];
  assign bus.out_last   = last_beat;
  assign bus.busy       = (state_q == READ) || (state_q == FLUSH);
  assign bus.done       = (state_q == FIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ: begin
        if (len_q == '0)     state_d = FIN;
        else if (last_issue) state_d = FLUSH;
      end
      FLUSH:   if (pop && last_beat) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the job on start; walk the read index and count issued reads and sent beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (start_ok) begin
        len_q    <= bus.len;
        rd_cnt_q <= '0;
        beats_q  <= '0;
        if (bus.len != '0) idx_q <= bus.base_idx;
      end else begin
        if (issue) begin
          rd_cnt_q <= rd_cnt_q + (IDX_W+1)'(1);
          // The index stays on the last word read once the final read issues.
          if (!last_issue) idx_q <= idx_q + IDX_W'(1);
        end
        if (pop) beats_q <= beats_q + (IDX_W+1)'(1);
      end
    end
  end

  // Skid FIFO: capture read data one cycle after issue, pop on host handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= bus.gbuf_rdata;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_gbuff_out_drain.sv
// Bench for gbuff_out_drain: a table of drain jobs plus random jobs, each checked
// against a queue of expected words built straight from the buffer contents.
module tb_gbuff_out_drain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gbuff_out_drain_if #(.WORD_W(32), .IDX_W(8)) bus ();

  gbuff_out_drain #(.WORD_W(32), .IDX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];

  // OUT buffer model: one-cycle read latency.
  always @(posedge clk) bus.gbuf_rdata <= mem[bus.gbuf_index];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] base;
    int         len;
    int         mode;      // 0: ready always 1, 1: ready 1,0,0 repeating, 2: random
    int         exp_done;  // expected done cycle after start, -1 when not fixed
    bit         repulse;   // pulse start while busy and during FIN
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 2) != 0;
  endfunction

  task automatic run_drain(input logic [7:0] base, input int len, input int mode,
                           input int exp_done, input bit repulse, input int rst_beat);
    logic [31:0] exp_q [$];
    int cyc, beats, done_cnt, done_cyc, first_v;
    logic hv, hl;
    logic [31:0] hd;
    bit stop;
    int budget;
    logic [7:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 8'(i);
      exp_q.push_back(mem[a]);
    end
    beats = 0; done_cnt = 0; done_cyc = 0; first_v = -1; hv = 1'b0; hl = 1'b0; hd = '0;
    stop = 1'b0; budget = len * 6 + 40;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_idx = base; bus.len = 9'(len);
    bus.out_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_idx = ~base; bus.len = 9'(len + 1);
    cyc = 1;
    bus.out_ready = ready_for(mode, 1);
    while (!stop) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_after_start", bus.busy, 1);
        if (len != 0) chk("first_index", bus.gbuf_index, base);
      end
      if (rst_beat >= 0 && bus.out_valid && beats == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("reset_mid_drain_outputs",
            {bus.out_valid, bus.out_last, bus.out_data, bus.busy, bus.done, bus.gbuf_index}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (hv) chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, hl, hd});
      hv = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      hl = bus.out_last;
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_overrun", beats + 1, len);
        end else begin
          chk("beat_data", bus.out_data, exp_q[0]);
          chk("beat_last", bus.out_last, exp_q.size() == 1);
          if (mode == 0) chk("beat_cycle", cyc, 3 + beats);
          void'(exp_q.pop_front());
        end
        beats++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        chk("done_after_all_beats", exp_q.size(), 0);
        chk("busy_low_in_done", bus.busy, 0);
        if (exp_done > 0) chk("done_cycle", cyc, exp_done);
      end
      if (done_cyc > 0 && cyc > done_cyc)
        chk("idle_after_done", {bus.busy, bus.out_valid, bus.done}, 0);
      if (done_cyc > 0 && cyc >= done_cyc + 3) stop = 1'b1;
      if (!stop && cyc > budget) begin
        chk("drain_timeout", done_cnt, 1);
        stop = 1'b1;
      end
      if (!stop) begin
        @(posedge clk); #1;
        cyc++;
        bus.out_ready = ready_for(mode, cyc);
        bus.start = repulse && (cyc == 2 || cyc == exp_done);
        if (bus.start) begin
          bus.base_idx = 8'h55;
          bus.len      = 9'd3;
        end
      end
    end
    bus.start = 1'b0;
    chk("beats_total", beats, len);
    chk("done_count", done_cnt, 1);
    if (mode == 0 && len != 0) chk("first_valid_cycle", first_v, 3);
    if (len == 0) chk("no_valid_for_len0", first_v, -1);
  endtask

  initial begin
    int len, mode;
    logic [7:0] base;
    tbl[0] = '{base: 8'h00, len: 4,   mode: 0, exp_done: 7,   repulse: 1'b0};
    tbl[1] = '{base: 8'h20, len: 0,   mode: 0, exp_done: 2,   repulse: 1'b0};
    tbl[2] = '{base: 8'h40, len: 6,   mode: 1, exp_done: -1,  repulse: 1'b0};
    tbl[3] = '{base: 8'hFE, len: 4,   mode: 0, exp_done: 7,   repulse: 1'b0};
    tbl[4] = '{base: 8'h10, len: 5,   mode: 0, exp_done: 8,   repulse: 1'b1};
    tbl[5] = '{base: 8'h00, len: 256, mode: 0, exp_done: 259, repulse: 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);

    rst = 1'b1;
    bus.start = 1'b0; bus.base_idx = '0; bus.len = '0; bus.out_ready = 1'b0;
    #1;
    chk("reset_outputs",
        {bus.out_valid, bus.out_last, bus.out_data, bus.busy, bus.done, bus.gbuf_index}, 0);
    chk("wr_en_low", bus.gbuf_wr_en, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i])
      run_drain(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].exp_done, tbl[i].repulse, -1);

    // Reset during the second beat of five, then a fresh drain from another base.
    run_drain(8'h30, 5, 0, -1, 1'b0, 1);
    run_drain(8'hA0, 5, 0, 8, 1'b0, -1);

    for (int r = 0; r < 25; r++) begin
      base = 8'($urandom);
      len  = $urandom_range(0, 24);
      mode = (r % 3 == 0) ? 0 : 2;
      run_drain(base, len, mode, (mode == 0) ? ((len == 0) ? 2 : len + 3) : -1, 1'b0, -1);
    end

    chk("wr_en_low_end", bus.gbuf_wr_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
